// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register target.
package i2c_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StPtr,
    StPtrAck,
    StWr,
    StWrAck,
    StRdShift,
    StRdAck,
    StIgnore
  } i2c_state_e;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam logic [6:0] DefaultChipAddr = 7'h3C;

endpackage

// File: rtl/i2c_target_regs_if.sv
// Single-cycle register port between the I2C target and the config register file.
interface i2c_target_regs_if;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;

  modport master (output reg_addr, output reg_wdata, output reg_we, output reg_re,
                  input reg_rdata);
  modport slave  (input reg_addr, input reg_wdata, input reg_we, input reg_re,
                  output reg_rdata);
endinterface

// File: rtl/i2c_line_filter.sv
// SCL/SDA conditioning: 2-FF sync, stability filter, edge and START/STOP detection.
module i2c_line_filter #(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_o,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  localparam int unsigned CntW = $clog2(FILTER_LEN);

  // Bit 0 carries SCL, bit 1 carries SDA.
  logic [1:0]      sync1_q, sync2_q, filt_q, prev_q;
  logic [CntW-1:0] cnt_q [2];

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
      filt_q  <= 2'b11;
      prev_q  <= 2'b11;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= {sda_i, scl_i};
      sync2_q <= sync1_q;
      prev_q  <= filt_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] != filt_q[i]) begin
          if (cnt_q[i] == CntW'(FILTER_LEN - 1)) begin
            filt_q[i] <= sync2_q[i];
            cnt_q[i]  <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + 1'b1;
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  assign scl_o      = filt_q[0];
  assign sda_o      = filt_q[1];
  assign scl_rise_o = filt_q[0] & ~prev_q[0];
  assign scl_fall_o = ~filt_q[0] & prev_q[0];
  assign start_o    = filt_q[0] & prev_q[0] & prev_q[1] & ~filt_q[1];
  assign stop_o     = filt_q[0] & prev_q[0] & ~prev_q[1] & filt_q[1];

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing an 8-bit register space with pointer auto-increment bursts.
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0]  CHIP_ADDR  = DefaultChipAddr,
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_oe_o,
  output logic busy_o,
  output logic nack_seen_o,
  i2c_target_regs_if.master reg_if
);

  logic scl_f, sda_f, scl_rise, scl_fall, start, stop;

  i2c_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filter (
    .clk       (clk),
    .reset     (reset),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl_o     (scl_f),
    .sda_o     (sda_f),
    .scl_rise_o(scl_rise),
    .scl_fall_o(scl_fall),
    .start_o   (start),
    .stop_o    (stop)
  );

  i2c_state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d, reg_addr_q, reg_addr_d, reg_wdata_q, reg_wdata_d;
  logic       phase_q, phase_d, sda_oe_q, sda_oe_d, busy_q, busy_d, nack_q, nack_d;
  logic       reg_we_q, reg_we_d, reg_re_q, reg_re_d, rd_load_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      shift_q     <= '0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      phase_q     <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      nack_q      <= 1'b0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      rd_load_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      phase_q     <= phase_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      nack_q      <= nack_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
      rd_load_q   <= reg_re_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    reg_wdata_d = reg_wdata_q;
    phase_d     = phase_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    nack_d      = 1'b0;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;
    reg_addr_d  = reg_we_q ? reg_addr_q + 8'd1 : reg_addr_q;

    unique case (state_q)
      StIdle: ;
      StAddr, StPtr, StWr: begin
        if (scl_rise) begin
          shift_d = {shift_q[6:0], sda_f};
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            phase_d = 1'b0;
            if (state_q == StPtr)                state_d = StPtrAck;
            else if (state_q == StWr)            state_d = StWrAck;
            else if (shift_q[6:0] == CHIP_ADDR)  state_d = StAddrAck;
            else                                 state_d = StIgnore;
          end
        end
      end
      // phase_q=0: waiting for the fall that opens the ACK slot; 1: inside it.
      StAddrAck, StPtrAck, StWrAck: begin
        if (scl_fall) begin
          if (!phase_q) begin
            phase_d  = 1'b1;
            sda_oe_d = 1'b1;
            if (state_q == StAddrAck) busy_d = 1'b1;
            if (state_q == StPtrAck)  reg_addr_d = shift_q;
            if (state_q == StWrAck) begin
              reg_wdata_d = shift_q;
              reg_we_d    = 1'b1;
            end
          end else begin
            phase_d  = 1'b0;
            sda_oe_d = 1'b0;
            cnt_d    = '0;
            if (state_q == StAddrAck) begin
              if (shift_q[0]) begin
                reg_re_d = 1'b1;
                state_d  = StRdShift;
              end else begin
                state_d = StPtr;
              end
            end else begin
              state_d = StWr;
            end
          end
        end
      end
      StRdShift: begin
        if (scl_fall) begin
          if (cnt_q == 3'd7) begin
            sda_oe_d = 1'b0;
            cnt_d    = '0;
            phase_d  = 1'b0;
            state_d  = StRdAck;
          end else begin
            cnt_d    = cnt_q + 3'd1;
            shift_d  = {shift_q[6:0], 1'b0};
            sda_oe_d = ~shift_q[6];
          end
        end
      end
      StRdAck: begin
        if (scl_rise) begin
          if (sda_f == I2C_NACK) begin
            nack_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StIgnore;
          end else begin
            phase_d = 1'b1;
          end
        end else if (scl_fall && phase_q) begin
          phase_d    = 1'b0;
          reg_addr_d = reg_addr_q + 8'd1;
          reg_re_d   = 1'b1;
          cnt_d      = '0;
          state_d    = StRdShift;
        end
      end
      StIgnore: begin
        sda_oe_d = 1'b0;
        busy_d   = 1'b0;
      end
      default: state_d = StIdle;
    endcase

    // Read data arrives one clk after reg_re; first bit goes out while SCL is still low.
    if (rd_load_q && state_q == StRdShift && !scl_f) begin
      shift_d  = reg_if.reg_rdata;
      sda_oe_d = ~reg_if.reg_rdata[7];
    end

    if (start) begin
      state_d  = StAddr;
      cnt_d    = '0;
      phase_d  = 1'b0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      reg_we_d = 1'b0;
      reg_re_d = 1'b0;
    end
    if (stop) begin
      state_d  = StIdle;
      cnt_d    = '0;
      phase_d  = 1'b0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      reg_we_d = 1'b0;
      reg_re_d = 1'b0;
    end
  end

  assign sda_oe_o         = sda_oe_q;
  assign busy_o           = busy_q;
  assign nack_seen_o      = nack_q;
  assign reg_if.reg_addr  = reg_addr_q;
  assign reg_if.reg_wdata = reg_wdata_q;
  assign reg_if.reg_we    = reg_we_q;
  assign reg_if.reg_re    = reg_re_q;

endmodule
